// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store unit bus master between the pipeline and the cpu_axi bridge
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_*_i / req_ready_o          one load/store at a time, accepted when valid & ready
//   resp_valid_o/err_o/rdata_o     one-cycle response, extended load data or store ack
//   r_*                            level-held read request handshake to the bridge
//   w_*                            level-held write request handshake to the bridge
module lsu_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [63:0] resp_rdata_o,
  output logic        r_addr_valid_o,
  output logic [63:0] r_addr_o,
  output logic [7:0]  r_byte_valid_o,
  input  logic        r_busy_i,
  input  logic        r_data_valid_i,
  input  logic [63:0] r_data_i,
  output logic        w_addr_valid_o,
  output logic [63:0] w_addr_o,
  output logic [63:0] w_data_o,
  output logic [7:0]  w_byte_valid_o,
  input  logic        w_busy_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_REL, S_WR_REQ, S_WR_WAIT, S_WR_REL, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          beat_q, beat_d;
  logic [31:0]   rbeat0_q, rbeat0_d;
  logic [31:0]   rbeat1_q, rbeat1_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  logic          misaligned;
  logic [1:0]    a;
  logic [63:0]   beat_addr;
  logic [3:0]    lanes;
  logic          last_beat;
  logic [31:0]   store_word;
  logic [31:0]   load_shifted;
  logic [63:0]   load_data;
  logic          timed_out;

  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = |req_addr_i[1:0];
      2'd3:    misaligned = |req_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Beat address, lanes and data all come from registered request fields, so
  // they stay stable for as long as a valid is held.
  assign a          = addr_q[1:0];
  assign beat_addr  = {addr_q[63:2], 2'b00} + (beat_q ? 64'd4 : 64'd0);
  assign last_beat  = (size_q != 2'd3) || beat_q;
  assign store_word = beat_q ? wdata_q[63:32] : (wdata_q[31:0] << {a, 3'b000});
  assign timed_out  = (timer_q == TW'(TIMEOUT));

  always_comb begin
    lanes = 4'b1111;
    case (size_q)
      2'd0:    lanes = 4'b0001 << a;
      2'd1:    lanes = 4'b0011 << a;
      default: lanes = 4'b1111;
    endcase
  end

  assign load_shifted = rbeat0_q >> {a, 3'b000};

  always_comb begin
    load_data = 64'd0;
    case (size_q)
      2'd0: load_data = {{56{~uns_q & load_shifted[7]}},  load_shifted[7:0]};
      2'd1: load_data = {{48{~uns_q & load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_data = {{32{~uns_q & load_shifted[31]}}, load_shifted[31:0]};
      default: load_data = {rbeat1_q, rbeat0_q};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    rbeat0_d = rbeat0_q;
    rbeat1_d = rbeat1_q;
    timer_d  = timer_q;
    err_d    = err_q;

    req_ready_o    = 1'b0;
    resp_valid_o   = 1'b0;
    resp_err_o     = 1'b0;
    resp_rdata_o   = 64'd0;
    r_addr_valid_o = 1'b0;
    r_addr_o       = 64'd0;
    r_byte_valid_o = 8'd0;
    w_addr_valid_o = 1'b0;
    w_addr_o       = 64'd0;
    w_data_o       = 64'd0;
    w_byte_valid_o = 8'd0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          beat_d  = 1'b0;
          timer_d = '0;
          err_d   = misaligned;
          if (misaligned)    state_d = S_RESP;
          else if (req_we_i) state_d = S_WR_REQ;
          else               state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        r_addr_valid_o = 1'b1;
        r_addr_o       = beat_addr;
        r_byte_valid_o = {4'b0000, lanes};
        timer_d        = timer_q + TW'(1);
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (r_data_valid_i) begin
          if (beat_q) rbeat1_d = r_data_i[31:0];
          else        rbeat0_d = r_data_i[31:0];
          state_d = S_RD_REL;
        end
      end
      S_RD_REL: begin
        // Release phase: the bridge must drop its data valid and go idle
        // before the next beat may be requested.
        timer_d = timer_q + TW'(1);
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (!r_data_valid_i && !r_busy_i) begin
          if (last_beat) begin
            state_d = S_RESP;
          end else begin
            beat_d  = 1'b1;
            timer_d = '0;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_REQ, S_WR_WAIT: begin
        w_addr_valid_o = 1'b1;
        w_addr_o       = beat_addr;
        w_data_o       = {32'd0, store_word};
        w_byte_valid_o = {4'b0000, lanes};
        timer_d        = timer_q + TW'(1);
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (state_q == S_WR_REQ && w_busy_i) begin
          state_d = S_WR_WAIT;
        end else if (state_q == S_WR_WAIT && !w_busy_i) begin
          state_d = S_WR_REL;
        end
      end
      S_WR_REL: begin
        if (last_beat) begin
          state_d = S_RESP;
        end else begin
          beat_d  = 1'b1;
          timer_d = '0;
          state_d = S_WR_REQ;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = (err_q || we_q) ? 64'd0 : load_data;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 64'd0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= 64'd0;
      beat_q   <= 1'b0;
      rbeat0_q <= 32'd0;
      rbeat1_q <= 32'd0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      rbeat0_q <= rbeat0_d;
      rbeat1_q <= rbeat1_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

endmodule
